sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
Serial-in parallel-out receiver, the counterpart of the team's 4-bit right-shift PISO. It accepts one bit per qualified clock, assembles WIDTH-bit words, and presents each completed word on a valid/ready output port. A holding register lets the next word be assembled while the previous one waits to be consumed. It sits at the far end of a PISO serial link and feeds a parallel consumer.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
serial_in  input  1  serial data bit; sampled only when serial_valid=1.
serial_valid  input  1  bit-qualify strobe; one bit is accepted per cycle it is high.
sync  input  1  frame alignment; discards any partial word and restarts at bit 0.
parallel_out  output  WIDTH  completed word; stable while out_valid=1.
out_valid  output  1  parallel_out holds an unconsumed word.
out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
busy  output  1  a partial word is in progress (state SHIFT).
overrun  output  1  sticky flag: a completed word was dropped.
clr_overrun  input  1  clears overrun.

Behaviour:
- Reset applies on the clock edge while rst=1:
  - state=IDLE, bit counter=0, shift register=0;
  - parallel_out=0, out_valid=0, busy=0, overrun=0.
  - rst overrides every other input. Reset mid-word discards the partial word and any held word.
- State machine:
  - IDLE: counter=0. On serial_valid, accept bit 0 and go to SHIFT.
  - SHIFT: each serial_valid accepts one bit and increments the counter. On the bit with counter==WIDTH-1, the word completes, the counter returns to 0 and state returns to IDLE.
- Bit order, default: LSB-first, matching the right-shift PISO. The first bit received lands in parallel_out[0]; the shift register shifts right with serial_in entering at MSB.
- Gaps: serial_valid=0 holds the counter and shift register. Gaps are unbounded.
- sync:
  - The counter and shift register clear and state goes to IDLE.
  - If serial_valid is also high in that cycle, that bit is taken as bit 0 of a new word (state SHIFT, counter=1).
  - sync never affects the holding register, out_valid or overrun.
- Completion latency: the word appears on parallel_out with out_valid=1 on the clock edge that samples the last bit. busy=0 in that same cycle, unless a new word has started.
- Handshake:
  - A transfer occurs when out_valid && out_ready at a rising edge. out_valid then falls the next cycle, unless a new word completes on that edge.
  - parallel_out and out_valid must not change while out_valid=1 and out_ready=0.
- Completion with the holding register free, or freed by a same-cycle transfer: the new word loads, out_valid=1, and overrun is not set.
- Completion with the holding register occupied and out_ready=0:
  - The new word is dropped and the held word is kept.
  - overrun is set on the next edge and stays set until clr_overrun=1 or reset.
  - If clr_overrun and a new overrun event occur in the same cycle, set wins.
- WIDTH=2 edge case: back-to-back completions every 2 cycles must sustain full throughput with out_ready held at 1.

Optional Feature:
Macro SIPO_MSB_FIRST_EN.
- Defined: MSB-first. The first bit received lands in parallel_out[WIDTH-1]; the register shifts left with serial_in entering at bit 0.
- Undefined: LSB-first, as above.
- All handshake, counter and overrun behaviour is identical either way.

Decomposition:
- Package sipo_pkg contains:
  - state enum (IDLE, SHIFT);
  - localparam SIPO_DEFAULT_WIDTH = 4.
- One sub-module is natural: sipo_out_buf, the one-entry valid/ready holding register with overrun detection. It takes a load strobe and data, and outputs parallel_out, out_valid and overrun.
- The shift register, counter and FSM stay in sipo_deserializer.

Test Plan:
- Reset, then send 4'b1101 LSB-first (bits 1,0,1,1) on consecutive cycles with out_ready=1 -> parallel_out=4'b1101 with out_valid=1 for one cycle; busy high for the middle cycles.
- Same word with serial_valid gaps of 3 cycles between bits -> identical result; the counter holds during gaps.
- out_ready=0; send 4'b1101 then 4'b0110 -> parallel_out stays 4'b1101, overrun=1 after the 8th bit. Pulse clr_overrun -> overrun=0. Raise out_ready -> one transfer of 4'b1101.
- Hold out_ready=0 until the cycle the second word completes, then set it to 1 -> 4'b1101 is transferred, 4'b0110 loads, out_valid stays 1, overrun stays 0.
- Send 2 bits, assert sync with serial_valid=1 and serial_in=1, then send bits 0,0,1 -> word 4'b1001; the partial bits are discarded.
- Assert rst after 3 bits with a word held -> all outputs 0 next cycle. A fresh 4'b1010 then decodes correctly. Repeat with SIPO_MSB_FIRST_EN defined: bits 1,1,0,1 -> 4'b1101.

Source files
------------

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared state encoding and default width for the SIPO receiver.
package sipo_pkg;
  typedef enum logic {IDLE, SHIFT} sipo_state_e;
  localparam int SIPO_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/sipo_out_buf.sv
// sipo_out_buf: one-entry valid/ready holding register with sticky overrun detection.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun
);
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, ovr_q, ovr_d, free;
  always_comb begin
    free = !valid_q || out_ready;
    data_d = (load && free) ? load_data : data_q;
    valid_d = (load && free) ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
    // a fresh drop wins over a same-cycle clear
    ovr_d = (load && !free) || (ovr_q && !clr_overrun);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      data_q <= data_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  end
  assign parallel_out = data_q;
  assign out_valid = valid_q;
  assign overrun = ovr_q;
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out receiver with valid/ready output and overrun flag.
// Define SIPO_MSB_FIRST_EN for MSB-first bit order; default is LSB-first.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);
  sipo_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, base, shifted;
  logic load, last;
  always_comb begin
    base = sync ? '0 : sh_q;
`ifdef SIPO_MSB_FIRST_EN
    shifted = {base[WIDTH-2:0], serial_in};
`else
    shifted = {serial_in, base[WIDTH-1:1]};
`endif
    last = !sync && (cnt_q == CNT_W'(WIDTH-1));
    load = serial_valid && last;
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    if (serial_valid) begin
      state_d = last ? IDLE : SHIFT;
      cnt_d = last ? '0 : (sync ? CNT_W'(1) : cnt_q + CNT_W'(1));
      sh_d = last ? '0 : shifted;
    end else if (sync) begin
      state_d = IDLE;
      cnt_d = '0;
      sh_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
    end
  end
  assign busy = (state_q == SHIFT);
  sipo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk(clk),
    .rst(rst),
    .load(load),
    .load_data(shifted),
    .out_ready(out_ready),
    .clr_overrun(clr_overrun),
    .parallel_out(parallel_out),
    .out_valid(out_valid),
    .overrun(overrun)
  );
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed checks of framing, gaps, sync, handshake, overrun and reset.
module tb_sipo_deserializer;
`ifdef SIPO_MSB_FIRST_EN
  localparam logic [3:0] W_A = 4'b1011;
  localparam logic [3:0] W_B = 4'b0110;
  localparam logic [3:0] W_S = 4'b1001;
  localparam logic [3:0] W_R = 4'b0101;
  localparam logic [1:0] T_0 = 2'b10;
  localparam logic [1:0] T_1 = 2'b11;
`else
  localparam logic [3:0] W_A = 4'b1101;
  localparam logic [3:0] W_B = 4'b0110;
  localparam logic [3:0] W_S = 4'b1001;
  localparam logic [3:0] W_R = 4'b1010;
  localparam logic [1:0] T_0 = 2'b01;
  localparam logic [1:0] T_1 = 2'b11;
`endif
  logic clk = 1'b0;
  logic rst, serial_in, serial_valid, sync, out_ready, clr_overrun;
  logic [3:0] parallel_out;
  logic out_valid, busy, overrun;
  logic s2_in, s2_valid;
  logic [1:0] p2_out;
  logic v2, b2, o2;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  sipo_deserializer dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .sync(sync), .parallel_out(parallel_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );
  sipo_deserializer #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .serial_in(s2_in), .serial_valid(s2_valid),
    .sync(1'b0), .parallel_out(p2_out), .out_valid(v2),
    .out_ready(1'b1), .busy(b2), .overrun(o2), .clr_overrun(1'b0)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic b);
    serial_valid = 1'b1;
    serial_in = b;
    step();
    serial_valid = 1'b0;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1; serial_in = 0; serial_valid = 0; sync = 0; out_ready = 0; clr_overrun = 0;
    s2_in = 0; s2_valid = 0;
    step(); step();
    check("rst_po", 32'(parallel_out), 0);
    check("rst_flags", {out_valid, busy, overrun}, 0);
    rst = 0;
    out_ready = 1;
    send(1); check("b0_busy", {busy, out_valid}, 2'b10);
    send(0); check("b1_busy", {busy, out_valid}, 2'b10);
    send(1); check("b2_busy", {busy, out_valid}, 2'b10);
    send(1);
    check("w1_po", 32'(parallel_out), 32'(W_A));
    check("w1_flags", {out_valid, busy, overrun}, 3'b100);
    step(); check("w1_xfer", 32'(out_valid), 0);
    send(1); repeat (3) step();
    check("gap_busy", {busy, out_valid}, 2'b10);
    send(0); repeat (3) step();
    send(1); repeat (3) step();
    check("gap_hold", {busy, out_valid}, 2'b10);
    send(1);
    check("gap_po", 32'(parallel_out), 32'(W_A));
    check("gap_flags", {out_valid, busy}, 2'b10);
    step(); check("gap_xfer", 32'(out_valid), 0);
    out_ready = 0;
    send(1); send(0); send(1); send(1);
    check("ovr_first", {28'(0), parallel_out} | (32'(out_valid) << 8), 32'(W_A) | 32'h100);
    send(0); send(1); send(1);
    check("ovr_pre", 32'(overrun), 0);
    send(0);
    check("ovr_po", 32'(parallel_out), 32'(W_A));
    check("ovr_set", {out_valid, overrun}, 2'b11);
    step(); check("ovr_sticky", 32'(overrun), 1);
    clr_overrun = 1; step(); clr_overrun = 0;
    check("ovr_clr", {out_valid, overrun}, 2'b10);
    out_ready = 1; step(); out_ready = 0;
    check("ovr_xfer", 32'(out_valid), 0);
    send(1); send(0); send(1); send(1);
    send(0); send(1); send(1);
    out_ready = 1;
    send(0);
    check("same_po", 32'(parallel_out), 32'(W_B));
    check("same_flags", {out_valid, overrun}, 2'b10);
    step(); check("same_xfer", 32'(out_valid), 0);
    send(1); send(1);
    sync = 1; serial_valid = 1; serial_in = 1; step(); sync = 0; serial_valid = 0;
    check("sync_busy", {busy, out_valid}, 2'b10);
    send(0); send(0);
    check("sync_mid", 32'(out_valid), 0);
    send(1);
    check("sync_po", 32'(parallel_out), 32'(W_S));
    check("sync_flags", {out_valid, busy, overrun}, 3'b100);
    step();
    out_ready = 0;
    send(1); send(0); send(1); send(1);
    send(1); send(1); send(1);
    check("pre_rst", {out_valid, busy}, 2'b11);
    rst = 1; step(); rst = 0;
    check("mid_rst_po", 32'(parallel_out), 0);
    check("mid_rst_flags", {out_valid, busy, overrun}, 0);
    out_ready = 1;
    send(0); send(1); send(0); send(1);
    check("post_rst_po", 32'(parallel_out), 32'(W_R));
    check("post_rst_flags", {out_valid, overrun}, 2'b10);
    step();
    s2_valid = 1;
    s2_in = 1; step(); check("w2_b0", {v2, b2}, 2'b01);
    s2_in = 0; step(); check("w2_a", {30'(0), p2_out} | (32'(v2) << 4), 32'(T_0) | 32'h10);
    s2_in = 1; step(); check("w2_b2", {v2, b2}, 2'b01);
    s2_in = 1; step(); check("w2_b", {30'(0), p2_out} | (32'(v2) << 4), 32'(T_1) | 32'h10);
    s2_in = 0; step(); check("w2_b4", {v2, b2}, 2'b01);
    s2_in = 0; step(); check("w2_c", {30'(0), p2_out} | (32'(v2) << 4), 32'h10);
    s2_valid = 0;
    step(); check("w2_end", {v2, b2, o2}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
